hs_merge_arbiter: RTL and testbench

HS_MERGE_ARBITER -- requirements
Module: hs_merge_arbiter

---
 rtl/hs_arb_pkg.sv | 23 ++
 rtl/hs_merge_arbiter_if.sv | 43 ++++
 rtl/hs_sync.sv | 33 +++
 rtl/hs_merge_arbiter.sv | 162 ++++++++++++++++
 tb/tb_hs_merge_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hs_arb_pkg.sv
// ============================================================================
//  Module   : hs_arb_pkg
//  Purpose  : Shared defaults and FSM state encoding for hs_merge_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hs_arb_pkg;

    localparam int DEF_N           = 4;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        RETURN = 2'd2,
        LACK   = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/hs_merge_arbiter_if.sv
// ============================================================================
//  Module   : hs_merge_arbiter_if
//  Purpose  : Four-phase input channels plus merged output channel bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface hs_merge_arbiter_if
    import hs_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH
);

    logic [N-1:0]            lreq;
    logic [N-1:0][WIDTH-1:0] ldata;
    logic [N-1:0]            lack;
    logic                    rreq;
    logic                    rack;
    logic [WIDTH-1:0]        rdata;

    // master: the environment (senders and downstream stage); slave: the arbiter
    modport master (
        output lreq,
        output ldata,
        output rack,
        input  lack,
        input  rreq,
        input  rdata
    );

    modport slave (
        input  lreq,
        input  ldata,
        input  rack,
        output lack,
        output rreq,
        output rdata
    );

endinterface

`default_nettype wire

// File: rtl/hs_sync.sv
// ============================================================================
//  Module   : hs_sync
//  Purpose  : Single-bit multi-flop synchronizer with async active-low reset.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hs_sync
    import hs_arb_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
        end
    end

    assign q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/hs_merge_arbiter.sv
// ============================================================================
//  Module   : hs_merge_arbiter
//  Purpose  : Round-robin merge of N four-phase channels into one channel.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hs_merge_arbiter
    import hs_arb_pkg::*;
#(
    parameter  int N           = DEF_N,
    parameter  int WIDTH       = DEF_WIDTH,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int ID_W        = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hs_merge_arbiter_if.slave   bus,
    output logic [ID_W-1:0]     grant_id,
    output logic                busy,
    output logic [15:0]         xfer_count
);

    logic [N-1:0]     lreq_s;
    logic             rack_s;

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_grant;
    logic [N-1:0]     r_lack;
    logic             r_rreq;
    logic [WIDTH-1:0] r_rdata;
    logic [15:0]      r_count;

    logic [ID_W-1:0]  w_pick;
    logic             w_found;
    logic [N-1:0]     w_grant_oh;
    logic             w_load;
    logic             w_rreq_clr;
    logic             w_lack_set;
    logic             w_done;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lreq_sync
            hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (bus.lreq[gi]),
                .q     (lreq_s[gi])
            );
        end
    endgenerate

    hs_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rack),
        .q     (rack_s)
    );

    // Search starts one past the last served channel, so that channel has lowest priority.
    always_comb begin : p_pick
        logic [ID_W-1:0] idx;
        w_pick  = r_ptr;
        w_found = 1'b0;
        idx     = r_ptr;
        for (int k = 0; k < N; k++) begin
            idx = (idx == ID_W'(N - 1)) ? '0 : idx + 1'b1;
            if (!w_found && lreq_s[idx]) begin
                w_found = 1'b1;
                w_pick  = idx;
            end
        end
    end

    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rreq_clr  = 1'b0;
        w_lack_set  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = SEND;
                    w_load      = 1'b1;
                end
            end
            SEND: begin
                if (rack_s) begin
                    w_state_nxt = RETURN;
                    w_rreq_clr  = 1'b1;
                end
            end
            RETURN: begin
                if (!rack_s) begin
                    w_state_nxt = LACK;
                    w_lack_set  = 1'b1;
                end
            end
            LACK: begin
                if (!lreq_s[r_grant]) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= ID_W'(N - 1);
            r_grant <= '0;
            r_lack  <= '0;
            r_rreq  <= 1'b0;
            r_rdata <= '0;
            r_count <= '0;
        end else begin
            if (w_load) begin
                r_rdata <= bus.ldata[w_pick];
                r_grant <= w_pick;
                r_rreq  <= 1'b1;
            end
            if (w_rreq_clr) begin
                r_rreq <= 1'b0;
            end
            if (w_lack_set) begin
                r_lack <= w_grant_oh;
            end
            if (w_done) begin
                r_lack  <= '0;
                r_ptr   <= r_grant;
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.lack   = r_lack;
    assign bus.rreq   = r_rreq;
    assign bus.rdata  = r_rdata;
    assign grant_id   = r_grant;
    assign busy       = (r_state != IDLE);
    assign xfer_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_hs_merge_arbiter.sv
// ============================================================================
//  Module   : tb_hs_merge_arbiter
//  Purpose  : Directed scenarios plus randomized traffic against a queue-free RR model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hs_merge_arbiter;
    import hs_arb_pkg::*;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SS    = 2;
    localparam int LAT   = SS + 1;
    localparam int IW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic [15:0]   xfer_count;

    int            checks = 0;
    int            errors = 0;
    logic [15:0]   exp_count = '0;

    hs_merge_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    hs_merge_arbiter #(.N(N), .WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .grant_id   (grant_id),
        .busy       (busy),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("lack_onehot0", 32'($countones(bus.lack) <= 1), 32'd1);
            check_eq("lack_rreq_excl", 32'(bus.rreq && (bus.lack != '0)), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rreq(input logic lvl);
        int n = 0;
        while (bus.rreq !== lvl && n < 40) begin
            tick();
            n++;
        end
        check_eq("rreq_wait", 32'(bus.rreq === lvl), 32'd1);
    endtask

    task automatic wait_lack(input logic [N-1:0] v);
        int n = 0;
        while (bus.lack !== v && n < 40) begin
            tick();
            n++;
        end
        check_eq("lack_wait", 32'(bus.lack), 32'(v));
    endtask

    task automatic apply_reset();
        bus.lreq = '0;
        bus.rack = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        rst_n     = 1'b1;
        exp_count = '0;
        tick();
    endtask

    // One full four-phase transfer for channel g, expecting data d on rdata.
    task automatic do_xfer(input logic [IW-1:0] g, input logic [WIDTH-1:0] d, input bit rereq);
        logic [N-1:0] oh;
        oh = '0;
        oh[g] = 1'b1;
        wait_rreq(1'b1);
        check_eq("grant_id", 32'(grant_id), 32'(g));
        check_eq("rdata", 32'(bus.rdata), 32'(d));
        check_eq("busy", 32'(busy), 32'd1);
        bus.rack = 1'b1;
        wait_rreq(1'b0);
        check_eq("rdata_hold", 32'(bus.rdata), 32'(d));
        bus.rack = 1'b0;
        wait_lack(oh);
        repeat (3) tick();
        check_eq("lack_held", 32'(bus.lack), 32'(oh));
        bus.lreq[g] = 1'b0;
        wait_lack('0);
        exp_count = exp_count + 16'd1;
        check_eq("xfer_count", 32'(xfer_count), 32'(exp_count));
        if (rereq) begin
            bus.ldata[g] = WIDTH'($urandom);
            bus.lreq[g]  = 1'b1;
        end
    endtask

    // Model: winner is the first channel after the last served one whose request was
    // visible LAT edges before rreq rose; every lack fall completes one transfer.
    task automatic run_random(input int cycles);
        logic [N-1:0]  hist [8];
        logic [N-1:0]  el;
        logic [N-1:0]  prev_lack;
        logic [N-1:0]  oh;
        logic          prev_rreq;
        logic          found;
        logic [IW-1:0] m_ptr;
        logic [IW-1:0] m_win;
        logic [IW-1:0] ix;
        for (int i = 0; i < 8; i++) hist[i] = '0;
        prev_lack = '0;
        prev_rreq = 1'b0;
        m_ptr     = IW'(N - 1);
        m_win     = '0;
        for (int c = 1; c <= cycles; c++) begin
            tick();
            if (bus.rreq && !prev_rreq) begin
                el    = hist[(c + 8 - LAT) % 8];
                found = 1'b0;
                check_eq("rnd_eligible", 32'(el != '0), 32'd1);
                for (int k = 1; k <= N; k++) begin
                    ix = IW'((int'(m_ptr) + k) % N);
                    if (!found && el[ix]) begin
                        found = 1'b1;
                        m_win = ix;
                    end
                end
                check_eq("rnd_grant", 32'(grant_id), 32'(m_win));
                check_eq("rnd_rdata", 32'(bus.rdata), 32'(bus.ldata[m_win]));
            end
            if (bus.lack != '0 && prev_lack == '0) begin
                oh = '0;
                oh[m_win] = 1'b1;
                check_eq("rnd_lack", 32'(bus.lack), 32'(oh));
            end
            if (bus.lack == '0 && prev_lack != '0) begin
                exp_count = exp_count + 16'd1;
                m_ptr     = m_win;
                check_eq("rnd_count", 32'(xfer_count), 32'(exp_count));
            end
            prev_rreq = bus.rreq;
            prev_lack = bus.lack;
            if (bus.rack != bus.rreq && $urandom_range(0, 1) == 1) bus.rack = bus.rreq;
            for (int i = 0; i < N; i++) begin
                ix = IW'(i);
                if (bus.lreq[ix] && bus.lack[ix] && $urandom_range(0, 1) == 1) begin
                    bus.lreq[ix] = 1'b0;
                end else if (!bus.lreq[ix] && !bus.lack[ix] && $urandom_range(0, 3) == 0) begin
                    bus.ldata[ix] = WIDTH'($urandom);
                    bus.lreq[ix]  = 1'b1;
                end
            end
            hist[c % 8] = bus.lreq;
        end
    endtask

    initial begin
        bus.lreq  = '0;
        bus.ldata = '0;
        bus.rack  = 1'b0;
        repeat (3) tick();
        check_eq("rst_lack", 32'(bus.lack), 32'd0);
        check_eq("rst_rreq", 32'(bus.rreq), 32'd0);
        check_eq("rst_rdata", 32'(bus.rdata), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(xfer_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single transfer with exact request-to-rreq latency
        bus.ldata[2] = 8'hA5;
        bus.lreq[2]  = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            check_eq("latency", 32'(bus.rreq), 32'(e == LAT));
        end
        do_xfer(2'd2, 8'hA5, 1'b0);

        // Contention: all requests held from reset
        bus.rack = 1'b0;
        rst_n    = 1'b0;
        for (int i = 0; i < N; i++) bus.ldata[IW'(i)] = WIDTH'($urandom);
        bus.lreq = '1;
        repeat (2) tick();
        rst_n     = 1'b1;
        exp_count = '0;
        for (int k = 0; k < 5; k++) begin
            do_xfer(IW'(k % N), bus.ldata[IW'(k % N)], 1'b1);
        end

        // Late request arriving during SEND
        apply_reset();
        bus.ldata[3] = 8'h5A;
        bus.lreq[3]  = 1'b1;
        wait_rreq(1'b1);
        bus.ldata[1] = 8'h3C;
        bus.lreq[1]  = 1'b1;
        do_xfer(2'd3, 8'h5A, 1'b0);
        do_xfer(2'd1, 8'h3C, 1'b0);

        // Reset while in RETURN
        apply_reset();
        bus.ldata[2] = 8'h11;
        bus.lreq[2]  = 1'b1;
        do_xfer(2'd2, 8'h11, 1'b0);
        bus.ldata[0] = 8'h77;
        bus.lreq[0]  = 1'b1;
        wait_rreq(1'b1);
        bus.rack = 1'b1;
        wait_rreq(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rreq", 32'(bus.rreq), 32'd0);
        check_eq("arst_lack", 32'(bus.lack), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_count", 32'(xfer_count), 32'd0);
        bus.rack = 1'b0;
        repeat (2) tick();
        rst_n     = 1'b1;
        exp_count = '0;
        do_xfer(2'd0, 8'h77, 1'b0);

        // Counter wrap from 0xFFFF
        repeat (2) tick();
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        tick();
        check_eq("count_preload", 32'(xfer_count), 32'hFFFF);
        exp_count    = 16'hFFFF;
        bus.ldata[1] = 8'hC3;
        bus.lreq[1]  = 1'b1;
        do_xfer(2'd1, 8'hC3, 1'b0);
        check_eq("count_wrap", 32'(xfer_count), 32'd0);

        // Sub-cycle glitch that no clock edge captures
        apply_reset();
        #2;
        bus.lreq[0] = 1'b1;
        #3;
        bus.lreq[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            check_eq("glitch_rreq", 32'(bus.rreq), 32'd0);
            check_eq("glitch_lack", 32'(bus.lack), 32'd0);
        end
        check_eq("glitch_count", 32'(xfer_count), 32'd0);

        apply_reset();
        run_random(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
